// File: rtl/usb_reg_responder.sv
// usb_reg_responder
//   FPGA-side responder for the CW305 parallel USB register bus. Host byte
//   writes and byte reads are decoded into single-cycle register-file
//   strobes. Read data goes back to the pads inside the host's two-cycle
//   sample window. Illegal bus cycles raise a pulse and bump a saturating
//   counter.
//
// Ports
//   usb_clk        bus clock, all logic on the rising edge
//   pushbutton     synchronous active-low reset
//   usb_addr       host address {block, reg_addr, subbyte}
//   usb_din        host write data from the pad
//   usb_dout       read data to the pad
//   usb_isout      pad tristate enable (1 = FPGA drives usb_data)
//   usb_rdn/wrn    host read/write strobes, active-low
//   usb_cen        host chip enable, active-low
//   reg_address    register address (registered usb_addr upper bits)
//   reg_bytecnt    byte index (registered usb_addr low bits)
//   reg_datao      write data to the register block
//   reg_datai      read data from the register block (combinational)
//   reg_write      one-cycle write strobe
//   reg_read       one-cycle read strobe
//   proto_err      one-cycle pulse on an illegal bus cycle
//   proto_err_cnt  saturating count of illegal bus cycles
//   dbg_state      current FSM state (IDLE=0, WR=1, RD=2, ERR=3)
//
// Strobe handshake: there is no back-pressure. reg_write and reg_read
// each assert for exactly one cycle per legal transaction. They never
// assert together. The register block must accept the strobe in the cycle
// it is high. reg_address/reg_bytecnt/reg_datao are stable in that cycle.
module usb_reg_responder #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                                   usb_clk,
    input  logic                                   pushbutton,
    input  logic [pADDR_WIDTH-1:0]                 usb_addr,
    input  logic [7:0]                             usb_din,
    output logic [7:0]                             usb_dout,
    output logic                                   usb_isout,
    input  logic                                   usb_rdn,
    input  logic                                   usb_wrn,
    input  logic                                   usb_cen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
    output logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    output logic [7:0]                             reg_datao,
    input  logic [7:0]                             reg_datai,
    output logic                                   reg_write,
    output logic                                   reg_read,
    output logic                                   proto_err,
    output logic [7:0]                             proto_err_cnt,
    output logic [1:0]                             dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                   state, state_nxt;
    logic [pADDR_WIDTH-1:0]   addr_r;
    logic [7:0]               din_r;
    logic                     rdn_r, wrn_r, cen_r;
    logic [7:0]               datao_nxt, dout_nxt;
    logic                     write_nxt, read_nxt, err_nxt;

    // Input stage: every decode below looks only at these registered copies.
    // Strobes idle high.
    always_ff @(posedge usb_clk) begin
        if (!pushbutton) begin
            addr_r <= '0;
            din_r  <= '0;
            rdn_r  <= 1'b1;
            wrn_r  <= 1'b1;
            cen_r  <= 1'b1;
        end else begin
            addr_r <= usb_addr;
            din_r  <= usb_din;
            rdn_r  <= usb_rdn;
            wrn_r  <= usb_wrn;
            cen_r  <= usb_cen;
        end
    end

    assign reg_address = addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE];
    assign reg_bytecnt = addr_r[pBYTECNT_SIZE-1:0];
    assign usb_isout   = (state == RD);
    assign dbg_state   = state;

    always_comb begin
        state_nxt = state;
        datao_nxt = reg_datao;
        dout_nxt  = usb_dout;
        write_nxt = 1'b0;
        read_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // Strobes moving while cen is high are host set-up and are ignored.
                if (!cen_r) begin
                    if (!rdn_r && !wrn_r) begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end else if (!wrn_r) begin
                        state_nxt = WR;
                        datao_nxt = din_r;
                    end else if (!rdn_r) begin
                        state_nxt = RD;
                        read_nxt  = 1'b1;
                    end
                end
            end
            WR: begin
                // The write is only committed when cen releases. A read strobe
                // seen first kills it.
                if (!rdn_r) begin
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
                end else if (cen_r) begin
                    state_nxt = IDLE;
                    write_nxt = 1'b1;
                end else begin
                    datao_nxt = din_r;
                end
            end
            RD: begin
                // Reload every edge so the pad sees data one edge after entry.
                dout_nxt = reg_datai;
                if (!wrn_r) begin
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
                end else if (rdn_r || cen_r) begin
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                if (cen_r && rdn_r && wrn_r) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge usb_clk) begin
        if (!pushbutton) begin
            state         <= IDLE;
            usb_dout      <= '0;
            reg_datao     <= '0;
            reg_write     <= 1'b0;
            reg_read      <= 1'b0;
            proto_err     <= 1'b0;
            proto_err_cnt <= '0;
        end else begin
            state     <= state_nxt;
            usb_dout  <= dout_nxt;
            reg_datao <= datao_nxt;
            reg_write <= write_nxt;
            reg_read  <= read_nxt;
            proto_err <= err_nxt;
            if (err_nxt && (proto_err_cnt != 8'hFF)) begin
                proto_err_cnt <= proto_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb_reg_responder.sv
module tb_usb_reg_responder;

    localparam int AW = 21;
    localparam int BW = 7;

    // ---------------- clock / reset ----------------
    logic usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;

    logic              pushbutton = 1'b0;
    logic [AW-1:0]     usb_addr   = '0;
    logic [7:0]        usb_din    = '0;
    logic              usb_rdn    = 1'b1;
    logic              usb_wrn    = 1'b1;
    logic              usb_cen    = 1'b1;
    logic [7:0]        reg_datai  = '0;
    logic [7:0]        usb_dout;
    logic              usb_isout;
    logic [AW-BW-1:0]  reg_address;
    logic [BW-1:0]     reg_bytecnt;
    logic [7:0]        reg_datao;
    logic              reg_write, reg_read, proto_err;
    logic [7:0]        proto_err_cnt;
    logic [1:0]        dbg_state;

    usb_reg_responder #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW)) dut (
        .usb_clk       (usb_clk),
        .pushbutton    (pushbutton),
        .usb_addr      (usb_addr),
        .usb_din       (usb_din),
        .usb_dout      (usb_dout),
        .usb_isout     (usb_isout),
        .usb_rdn       (usb_rdn),
        .usb_wrn       (usb_wrn),
        .usb_cen       (usb_cen),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_datao     (reg_datao),
        .reg_datai     (reg_datai),
        .reg_write     (reg_write),
        .reg_read      (reg_read),
        .proto_err     (proto_err),
        .proto_err_cnt (proto_err_cnt),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic [7:0] exp_q[$];

    always @(negedge usb_clk) begin
        if (reg_write) wr_cnt++;
        if (reg_read) rd_cnt++;
        if (proto_err) err_cnt++;
        if (reg_write && reg_read) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge usb_clk);
            #1;
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d,
                              input logic [AW-BW-1:0] exp_ra, input logic [BW-1:0] exp_rb);
        int wr0;
        wr0 = wr_cnt;
        usb_addr = a;
        usb_din  = d;
        usb_wrn  = 1'b0;
        step();
        usb_cen = 1'b0;
        step();
        usb_cen = 1'b1;
        step();
        usb_wrn = 1'b1;
        step();
        check("wr_strobe", reg_write, 1);
        check("wr_no_read", reg_read, 0);
        check("wr_addr", reg_address, exp_ra);
        check("wr_bytecnt", reg_bytecnt, exp_rb);
        check("wr_data", reg_datao, d);
        step(2);
        check("wr_count", wr_cnt - wr0, 1);
    endtask

    task automatic host_read(input logic [AW-1:0] a, input logic [7:0] d);
        usb_addr  = a;
        reg_datai = d;
        exp_q.push_back(d);
        usb_rdn = 1'b0;
        usb_cen = 1'b0;
        step();
        step();
        check("rd_isout", usb_isout, 1);
        check("rd_strobe", reg_read, 1);
        usb_rdn = 1'b1;
        usb_cen = 1'b1;
        step();
        check("rd_dout", usb_dout, exp_q.pop_front());
        step();
        check("rd_release", usb_isout, 0);
        step();
    endtask

    task automatic illegal(input int n_low);
        usb_rdn = 1'b0;
        usb_wrn = 1'b0;
        usb_cen = 1'b0;
        step(n_low);
        usb_rdn = 1'b1;
        usb_wrn = 1'b1;
        usb_cen = 1'b1;
        step(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wr0, rd0, er0;

        pushbutton = 1'b0;
        step(3);
        pushbutton = 1'b1;
        step();
        check("rst_state", dbg_state, 0);
        check("rst_dout", usb_dout, 0);
        check("rst_isout", usb_isout, 0);
        check("rst_datao", reg_datao, 0);
        check("rst_write", reg_write, 0);
        check("rst_read", reg_read, 0);
        check("rst_err", proto_err, 0);
        check("rst_errcnt", proto_err_cnt, 0);

        // Test 1: block 0, reg 0x05, subbyte 3 -> usb_addr 0x283
        host_write(21'h000283, 8'hA5, 14'h005, 7'd3);
        check("t1_errcnt", proto_err_cnt, 0);

        // Test 2: reg 0x02 subbyte 0 -> usb_addr 0x100
        rd0 = rd_cnt;
        host_read(21'h000100, 8'h3C);
        check("t2_rd_count", rd_cnt - rd0, 1);

        // Test 3: busy-poll, data 1 x15 then 0
        rd0 = rd_cnt;
        for (int i = 0; i < 16; i++) begin
            host_read(21'h000100, (i == 15) ? 8'h00 : 8'h01);
        end
        check("t3_rd_count", rd_cnt - rd0, 16);
        check("t3_errcnt", proto_err_cnt, 0);
        check("t3_q_empty", exp_q.size(), 0);

        // Test 4: illegal 3 cycles, then a legal write
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        er0 = err_cnt;
        illegal(3);
        check("t4_err_pulses", err_cnt - er0, 1);
        check("t4_errcnt", proto_err_cnt, 1);
        check("t4_no_wr", wr_cnt - wr0, 0);
        check("t4_no_rd", rd_cnt - rd0, 0);
        check("t4_idle", dbg_state, 0);
        host_write(21'h000283, 8'hA5, 14'h005, 7'd3);
        host_read(21'h000100, 8'h5A);

        // Test 5: reset while WR holds a committed-pending write
        wr0 = wr_cnt;
        usb_addr = 21'h000283;
        usb_din  = 8'h77;
        usb_wrn  = 1'b0;
        step();
        usb_cen = 1'b0;
        step();
        usb_cen = 1'b1;
        step();
        check("t5_in_wr", dbg_state, 1);
        usb_wrn    = 1'b1;
        pushbutton = 1'b0;
        step();
        check("t5_state", dbg_state, 0);
        check("t5_write", reg_write, 0);
        check("t5_dout", usb_dout, 0);
        check("t5_datao", reg_datao, 0);
        check("t5_errcnt", proto_err_cnt, 0);
        check("t5_addr", reg_address, 0);
        pushbutton = 1'b1;
        step(3);
        check("t5_no_wr", wr_cnt - wr0, 0);

        // Test 6: 300 separated illegal cycles saturate the counter
        er0 = err_cnt;
        repeat (300) illegal(1);
        check("t6_err_pulses", err_cnt - er0, 300);
        check("t6_errcnt_sat", proto_err_cnt, 255);
        pushbutton = 1'b0;
        step();
        pushbutton = 1'b1;
        step();
        check("t6_errcnt_clr", proto_err_cnt, 0);

        check("never_both", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
